vram_px_arbiter: RTL and testbench



---
 rtl/vram_px_arbiter.sv | 120 ++++++++++++
 tb/tb_vram_px_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_px_arbiter.sv
// Single-port pixel VRAM arbiter: the pixel engine always owns the slot, CPU writes
// are posted through a small FIFO, and CPU reads wait until that FIFO has drained.
module vram_px_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gpu_req,
  input  logic [ADDR_W-1:0] gpu_addr,
  output logic [DATA_W-1:0] gpu_q,
  input  logic              cpu_start,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_d,
  output logic              vram_we,
  input  logic [DATA_W-1:0] vram_q
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_FULL, RD_WAIT, RD_DATA} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] buf_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] buf_data [WBUF_DEPTH];
  logic [ADDR_W-1:0] held_addr;
  logic [DATA_W-1:0] held_data;

  logic              not_full, rd_issue, pop, push, push_cpu, latch, done_nxt;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;

  // Slot decision, FIFO bookkeeping and FSM next state
  always_comb begin
    not_full  = (count != FULL_CNT);
    // Reset suppresses RAM activity so discarded writes never reach the array
    rd_issue  = !reset && !gpu_req && (state == RD_WAIT) && (count == '0);
    pop       = !reset && !gpu_req && !rd_issue && (count != '0);
    push_cpu  = (state == IDLE) && cpu_start && cpu_we && not_full;
    push      = push_cpu || ((state == WR_FULL) && not_full);
    latch     = (state == IDLE) && cpu_start;
    push_addr = push_cpu ? cpu_addr : held_addr;
    push_data = push_cpu ? cpu_data : held_data;

    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu_start) begin
          if (!cpu_we)        state_nxt = RD_WAIT;
          else if (!not_full) state_nxt = WR_FULL;
        end
      end
      WR_FULL: if (not_full) state_nxt = IDLE;
      RD_WAIT: if (rd_issue) state_nxt = RD_DATA;
      RD_DATA: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    // A stalled write completes in the cycle its entry is pushed, i.e. right after a pop frees space
    done_nxt  = push_cpu
             || ((state_nxt == WR_FULL) && (count_nxt != FULL_CNT))
             || (state == RD_DATA);
  end

  always_comb begin
    vram_we = pop;
    vram_d  = buf_data[rd_ptr];
    if (gpu_req)       vram_addr = gpu_addr;
    else if (rd_issue) vram_addr = held_addr;
    else if (pop)      vram_addr = buf_addr[rd_ptr];
    else               vram_addr = gpu_addr;
  end

  assign gpu_q    = vram_q;
  assign cpu_busy = (state != IDLE);

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cpu_done <= 1'b0;
      cpu_q    <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      cpu_done <= done_nxt;
      if (push)             wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)              rd_ptr <= rd_ptr + PTR_W'(1);
      if (state == RD_DATA) cpu_q  <= vram_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= push_addr;
      buf_data[wr_ptr] <= push_data;
    end
    if (latch) begin
      held_addr <= cpu_addr;
      held_data <= cpu_data;
    end
  end

endmodule

// File: tb/tb_vram_px_arbiter.sv
// Bench for vram_px_arbiter: RAM model, expected-write queue and shadow memory as the reference.
module tb_vram_px_arbiter;
  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 8;
  localparam int WBUF_DEPTH = 4;
  localparam int RAM_SZ     = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, gpu_req, cpu_start, cpu_we;
  logic [ADDR_W-1:0] gpu_addr, cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic [DATA_W-1:0] gpu_q, cpu_q, vram_d, vram_q;
  logic [ADDR_W-1:0] vram_addr;
  logic              cpu_done, cpu_busy, vram_we;

  vram_px_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(WBUF_DEPTH)) dut (
    .clk(clk), .reset(reset), .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_q(gpu_q),
    .cpu_start(cpu_start), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_q(cpu_q), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
    .vram_addr(vram_addr), .vram_d(vram_d), .vram_we(vram_we), .vram_q(vram_q)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic [DATA_W-1:0] ram    [RAM_SZ];
  logic [DATA_W-1:0] shadow [RAM_SZ];
  wr_t               wq [$];
  int                errors = 0;
  int                checks = 0;
  logic              gpu_rand = 1'b0;
  logic              gpu_force = 1'b0;

  // RAM model: one-cycle read latency, write on the same edge
  always @(posedge clk) begin
    if (vram_we) ram[vram_addr] <= vram_d;
    vram_q <= ram[vram_addr];
  end

  // Pixel engine request generator
  initial begin
    gpu_req  = 1'b0;
    gpu_addr = '0;
    forever begin
      @(posedge clk);
      #2;
      gpu_addr = ADDR_W'($urandom);
      gpu_req  = gpu_rand ? 1'($urandom) : gpu_force;
    end
  end

  // Continuous slot monitor
  initial begin
    logic              gpu_prev;
    logic [DATA_W-1:0] gpu_exp;
    wr_t               e;
    gpu_prev = 1'b0;
    gpu_exp  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (gpu_prev) begin
          checks++;
          if (gpu_q !== gpu_exp) begin
            errors++;
            $display("FAIL gpu_q: got %h expected %h", gpu_q, gpu_exp);
          end
        end
        if (gpu_req) begin
          checks++;
          if (vram_we !== 1'b0 || vram_addr !== gpu_addr) begin
            errors++;
            $display("FAIL gpu_slot: we=%b addr=%h expected we=0 addr=%h", vram_we, vram_addr, gpu_addr);
          end
        end
        if (vram_we === 1'b1) begin
          checks++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%h data=%h expected no write", vram_addr, vram_d);
          end else begin
            e = wq.pop_front();
            if (vram_addr !== e.a || vram_d !== e.d) begin
              errors++;
              $display("FAIL write_order: got %h<-%h expected %h<-%h", vram_addr, vram_d, e.a, e.d);
            end
          end
        end
      end
      gpu_prev = gpu_req;
      gpu_exp  = ram[gpu_addr];
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, expected the bench to finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    gpu_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", cpu_busy); end
    checks++; if (cpu_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", cpu_done); end
    checks++; if (cpu_q !== '0) begin errors++; $display("FAIL rst_cpu_q: got %h expected 00", cpu_q); end
    @(negedge clk);
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", vram_we); end
    @(posedge clk); #1;
    reset = 1'b0;
    // Fill the buffer behind the pixel engine, stall a fifth write, then reset
    gpu_force = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i <= WBUF_DEPTH; i++) begin
      cpu_start = 1'b1; cpu_we = 1'b1;
      cpu_addr = ADDR_W'($urandom); cpu_data = DATA_W'($urandom);
      @(posedge clk); #1;
    end
    cpu_start = 1'b0;
    checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b expected 1", cpu_busy); end
    reset = 1'b1;
    gpu_force = 1'b0;
    @(negedge clk);
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %b expected 0", vram_we); end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", cpu_busy); end
    checks++; if (cpu_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", cpu_done); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL rst_no_write: got %b expected 0", vram_we); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_posted_write();
    wr_t e;
    gpu_force = 1'b0;
    cpu_start = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h01234; cpu_data = 8'hA5;
    e.a = 17'h01234; e.d = 8'hA5;
    wq.push_back(e);
    shadow[17'h01234] = 8'hA5;
    @(posedge clk); #1;
    cpu_start = 1'b0;
    checks++; if (cpu_done !== 1'b1) begin errors++; $display("FAIL pw_done: got %b expected 1", cpu_done); end
    @(negedge clk);
    checks++;
    if (vram_we !== 1'b1 || vram_addr !== 17'h01234 || vram_d !== 8'hA5) begin
      errors++;
      $display("FAIL pw_ram: got we=%b %h<-%h expected we=1 01234<-a5", vram_we, vram_addr, vram_d);
    end
    @(posedge clk); #1;
    checks++; if (cpu_done !== 1'b0) begin errors++; $display("FAIL pw_done_pulse: got %b expected 0", cpu_done); end
  endtask

  task automatic test_gpu_priority();
    wr_t e;
    gpu_force = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (cpu_done !== ((c >= 1 && c <= 4) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL prio_done c=%0d: got %b expected %b", c, cpu_done, (c >= 1 && c <= 4));
      end
      checks++;
      if (cpu_busy !== ((c >= 5) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL prio_busy c=%0d: got %b expected %b", c, cpu_busy, (c >= 5));
      end
      if (c < 5) begin
        cpu_start = 1'b1; cpu_we = 1'b1;
        cpu_addr = ADDR_W'(17'h02000 + c); cpu_data = DATA_W'($urandom);
        e.a = cpu_addr; e.d = cpu_data;
        wq.push_back(e);
        shadow[cpu_addr] = cpu_data;
      end else begin
        cpu_start = 1'b0;
      end
      @(negedge clk);
      checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL prio_no_we c=%0d: got %b expected 0", c, vram_we); end
      @(posedge clk); #1;
    end
    cpu_start = 1'b0;
    gpu_force = 1'b0;
    @(negedge clk);
    checks++; if (vram_we !== 1'b1) begin errors++; $display("FAIL prio_first_pop: got %b expected 1", vram_we); end
    @(posedge clk); #1;
    checks++; if (cpu_done !== 1'b1) begin errors++; $display("FAIL prio_fifth_done: got %b expected 1", cpu_done); end
    @(posedge clk); #1;
    checks++; if (cpu_done !== 1'b0 || cpu_busy !== 1'b0) begin
      errors++; $display("FAIL prio_after: got done=%b busy=%b expected 0 0", cpu_done, cpu_busy);
    end
    for (int w = 0; w < 20 && wq.size() != 0; w++) begin @(posedge clk); #1; end
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL prio_drain: got %0d pending expected 0", wq.size()); end
  endtask

  task automatic test_raw();
    wr_t e;
    int  w;
    gpu_force = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      cpu_start = 1'b1; cpu_we = 1'b1;
      cpu_addr = (c == 3) ? 17'h00010 : ADDR_W'(17'h00100 + c);
      cpu_data = (c == 3) ? 8'h3C : DATA_W'($urandom);
      e.a = cpu_addr; e.d = cpu_data;
      wq.push_back(e);
      shadow[cpu_addr] = cpu_data;
      @(posedge clk); #1;
    end
    cpu_start = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00010;
    @(posedge clk); #1;
    cpu_start = 1'b0;
    checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL raw_busy: got %b expected 1", cpu_busy); end
    gpu_force = 1'b0;
    w = 0;
    while (!cpu_done && w < 30) begin @(posedge clk); #1; w++; end
    checks++; if (cpu_done !== 1'b1) begin errors++; $display("FAIL raw_done: got %b expected 1", cpu_done); end
    checks++; if (cpu_q !== 8'h3C) begin errors++; $display("FAIL raw_data: got %h expected 3c", cpu_q); end
    checks++; if (w != 6) begin errors++; $display("FAIL raw_latency: got %0d expected 6", w); end
  endtask

  task automatic test_read_latency();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] exp;
    int                k;
    gpu_force = 1'b0;
    @(posedge clk); #1;
    for (int t = 0; t < 2; t++) begin
      a   = ADDR_W'(17'h10000 | ADDR_W'($urandom_range(0, 4095)));
      exp = shadow[a];
      cpu_start = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      @(posedge clk); #1;
      cpu_start = 1'b0;
      k = 1;
      forever begin
        gpu_force = (t == 1) && (k <= 5);
        if (cpu_done || k >= 40) break;
        @(posedge clk); #1;
        k++;
      end
      gpu_force = 1'b0;
      checks++; if (k != ((t == 0) ? 3 : 8)) begin
        errors++; $display("FAIL rd_latency t=%0d: got %0d expected %0d", t, k, (t == 0) ? 3 : 8);
      end
      checks++; if (cpu_q !== exp) begin errors++; $display("FAIL rd_data t=%0d: got %h expected %h", t, cpu_q, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dropped();
    logic [ADDR_W-1:0] a, z;
    logic [DATA_W-1:0] exp, held;
    int                dones;
    a = 17'h03000;
    z = 17'h03001;
    while (shadow[z] == shadow[a]) z = z + 1'b1;
    exp = shadow[a];
    gpu_force = 1'b1;
    cpu_start = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(posedge clk); #1;
    checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL drop_busy: got %b expected 1", cpu_busy); end
    dones = 0;
    cpu_start = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_data = ~exp;
    if (cpu_done) dones++;
    @(posedge clk); #1;
    cpu_start = 1'b1; cpu_we = 1'b0; cpu_addr = z;
    if (cpu_done) dones++;
    @(posedge clk); #1;
    cpu_start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 2) gpu_force = 1'b0;
      if (cpu_done) dones++;
      @(posedge clk); #1;
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL drop_dones: got %0d expected 1", dones); end
    checks++; if (cpu_q !== exp) begin errors++; $display("FAIL drop_data: got %h expected %h", cpu_q, exp); end
    held = cpu_q;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_q !== held) begin errors++; $display("FAIL cpu_q_hold: got %h expected %h", cpu_q, held); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] pool [8];
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, exp;
    logic              we;
    wr_t               e;
    int                w;
    for (int i = 0; i < 8; i++) pool[i] = ADDR_W'(17'h04000 + 3 * i);
    exp = '0;
    gpu_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom);
      a  = pool[$urandom_range(0, 7)];
      d  = DATA_W'($urandom);
      w = 0;
      while (cpu_busy && w < 100) begin @(posedge clk); #1; w++; end
      checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle n=%0d: got busy %b expected 0", n, cpu_busy); end
      cpu_start = 1'b1; cpu_we = we; cpu_addr = a; cpu_data = d;
      if (we) begin
        e.a = a; e.d = d;
        wq.push_back(e);
        shadow[a] = d;
      end else begin
        exp = shadow[a];
      end
      @(posedge clk); #1;
      cpu_start = 1'b0;
      w = 0;
      while (!cpu_done && w < 200) begin @(posedge clk); #1; w++; end
      checks++;
      if (cpu_done !== 1'b1) begin
        errors++; $display("FAIL b2b_done n=%0d: got %b expected 1", n, cpu_done);
      end else if (!we && cpu_q !== exp) begin
        errors++; $display("FAIL b2b_read n=%0d addr=%h: got %h expected %h", n, a, cpu_q, exp);
      end
    end
    gpu_rand = 1'b0;
    gpu_force = 1'b0;
    for (int k = 0; k < 50 && (wq.size() != 0 || cpu_busy); k++) begin @(posedge clk); #1; end
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending expected 0", wq.size()); end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram[pool[i]] !== shadow[pool[i]]) begin
        errors++; $display("FAIL b2b_ram addr=%h: got %h expected %h", pool[i], ram[pool[i]], shadow[pool[i]]);
      end
    end
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    reset = 1'b1;
    cpu_start = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
    for (int i = 0; i < RAM_SZ; i++) begin
      v = (i == 17'h00010) ? 8'h00 : DATA_W'($urandom);
      ram[i] <= v;
      shadow[i] = v;
    end
    test_reset();
    test_posted_write();
    test_gpu_priority();
    test_raw();
    test_read_latency();
    test_dropped();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
